// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern and length.
// Supports overlapping and non-overlapping detection and keeps a saturating match count.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1,
  localparam int LEN_W  = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  typedef enum logic [1:0] {UNCFG, FILL, TRACK} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] hist, hist_nxt, pat_q, mask;
  logic [LEN_W-1:0]   len_q, fill, fill_nxt;
  logic               accept, hit, len_ok, cnt_max;

  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], in_bit};
    fill_nxt = (fill < len_q) ? fill + LEN_W'(1) : fill;
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
    accept   = in_valid && (state != UNCFG) && !cfg_load;
    // Only the low len_q bits take part; stale pattern bits above are masked off.
    hit      = accept && (fill_nxt == len_q) && (((hist_nxt ^ pat_q) & mask) == '0);
    len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    cnt_max  = &match_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UNCFG;
      hist        <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
      cfg_err     <= 1'b0;
      armed       <= 1'b0;
    end else begin
      match <= hit;
      if (cnt_clr)
        match_count <= hit ? CNT_W'(1) : '0;
      else if (hit && !cnt_max)
        match_count <= match_count + CNT_W'(1);

      if (cfg_load) begin
        fill <= '0;
        if (len_ok) begin
          pat_q   <= cfg_pattern;
          len_q   <= cfg_len;
          cfg_err <= 1'b0;
          state   <= FILL;
          armed   <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
          state   <= UNCFG;
          armed   <= 1'b0;
        end
      end else if (accept) begin
        hist <= hist_nxt;
        // Non-overlapping mode restarts the fill so the next match needs fresh bits.
        if (hit && OVERLAP == 0) begin
          fill  <= '0;
          state <= FILL;
        end else begin
          fill <= fill_nxt;
          if (fill_nxt == len_q) state <= TRACK;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations driven in lockstep,
// compared every cycle against a bit-window reference model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       match_ov, match_no, match_c2;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_c2;
  logic       err_ov, err_no, err_c2;
  logic       arm_ov, arm_no, arm_c2;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(8), .OVERLAP(1)) dut_ov (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
    .match(match_ov), .match_count(cnt_ov), .cfg_err(err_ov), .armed(arm_ov));

  seq_detector_param #(.MAX_LEN(8), .CNT_W(8), .OVERLAP(0)) dut_no (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
    .match(match_no), .match_count(cnt_no), .cfg_err(err_no), .armed(arm_no));

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2), .OVERLAP(1)) dut_c2 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
    .match(match_c2), .match_count(cnt_c2), .cfg_err(err_c2), .armed(arm_c2));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: bits accepted since arming plus a window of recent bits.
  int              cmax[3] = '{255, 255, 3};
  int              ovl[3]  = '{1, 0, 1};
  longint unsigned m_win[3], m_pat[3];
  int              m_len[3], m_n[3], e_cnt[3];
  bit              m_arm[3], m_err[3], e_match[3];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_win[k] = 0; m_pat[k] = 0; m_len[k] = 0; m_n[k] = 0; e_cnt[k] = 0;
      m_arm[k] = 0; m_err[k] = 0; e_match[k] = 0;
    end
  endtask

  task automatic model_tick();
    longint unsigned msk;
    bit hit;
    for (int k = 0; k < 3; k++) begin
      hit = 0;
      if (cfg_load) begin
        if (cfg_len >= 1 && cfg_len <= 8) begin
          m_pat[k] = cfg_pattern; m_len[k] = cfg_len; m_n[k] = 0;
          m_arm[k] = 1; m_err[k] = 0;
        end else begin
          m_arm[k] = 0; m_err[k] = 1;
        end
      end else if (in_valid && m_arm[k]) begin
        m_win[k] = (m_win[k] << 1) | longint'(in_bit);
        m_n[k]++;
        msk = (64'd1 << m_len[k]) - 1;
        if (m_n[k] >= m_len[k] && (m_win[k] & msk) == (m_pat[k] & msk)) begin
          hit = 1;
          if (ovl[k] == 0) m_n[k] = 0;
        end
      end
      e_match[k] = hit;
      if (cnt_clr) e_cnt[k] = hit ? 1 : 0;
      else if (hit && e_cnt[k] < cmax[k]) e_cnt[k]++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_match_ov"}, int'(match_ov), int'(e_match[0]));
    chk({tag, "_match_no"}, int'(match_no), int'(e_match[1]));
    chk({tag, "_match_c2"}, int'(match_c2), int'(e_match[2]));
    chk({tag, "_cnt_ov"},   int'(cnt_ov),   e_cnt[0]);
    chk({tag, "_cnt_no"},   int'(cnt_no),   e_cnt[1]);
    chk({tag, "_cnt_c2"},   int'(cnt_c2),   e_cnt[2]);
    chk({tag, "_err"},      int'(err_ov),   int'(m_err[0]));
    chk({tag, "_arm"},      int'(arm_no),   int'(m_arm[1]));
    chk({tag, "_arm_c2"},   int'(arm_c2),   int'(m_arm[2]));
  endtask

  // Inputs are set ~1 time unit after a rising edge; model and DUT see the same edge.
  task automatic step(input string tag);
    model_tick();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input string tag);
    cfg_load = 1; cfg_pattern = pat; cfg_len = len;
    step(tag);
    cfg_load = 0;
  endtask

  task automatic send(input logic b, input string tag);
    in_valid = 1; in_bit = b;
    step(tag);
    in_valid = 0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  logic [6:0] s33 = 7'b1011011;
  logic [3:0] s1011 = 4'b1011;

  initial begin
    model_reset();
    #3;
    chk("rst_match", int'(match_ov | match_no | match_c2), 0);
    chk("rst_cnt",   int'(cnt_ov) + int'(cnt_no) + int'(cnt_c2), 0);
    chk("rst_flags", int'({err_ov, arm_ov, err_c2, arm_c2}), 0);
    @(posedge clk); #1;
    rst = 0;

    // Overlapping vs non-overlapping on 1011 with junk pattern bits above len.
    load(8'b1010_1011, 4'd4, "ld33");
    for (int i = 6; i >= 0; i--) send(s33[i], "s33");
    chk("req33_cnt_ov", int'(cnt_ov), 2);
    chk("req34_cnt_no", int'(cnt_no), 1);

    // Gaps of three idle cycles between valid bits.
    load(8'h0B, 4'd4, "ld35");
    for (int i = 3; i >= 0; i--) begin
      send(s1011[i], "s35");
      if (i == 0) chk("req35_pulse", int'(match_ov), 1);
      idle(3, "g35");
    end

    // Saturation of the 2-bit counter, then clear colliding with a match.
    cnt_clr = 1; step("clr"); cnt_clr = 0;
    load(8'h03, 4'd2, "ld36");
    for (int i = 0; i < 6; i++) send(1'b1, "s36");
    chk("req36_sat", int'(cnt_c2), 3);
    cnt_clr = 1; send(1'b1, "s36clr"); cnt_clr = 0;
    chk("req36_clr", int'(cnt_c2), 1);

    // Illegal lengths.
    load(8'h0B, 4'd0, "ld37");
    for (int i = 3; i >= 0; i--) send(s1011[i], "s37");
    load(8'h0B, 4'd9, "ld37b");
    chk("req37_err", int'(err_ov), 1);
    load(8'h0B, 4'd4, "ld37c");
    chk("req37_arm", int'(arm_ov), 1);

    // Asynchronous reset mid-cycle discards a partial sequence.
    for (int i = 3; i >= 1; i--) send(s1011[i], "s38");
    #2 rst = 1;
    #1;
    chk("req38_async", int'({match_ov, err_ov, arm_ov, arm_no, arm_c2}), 0);
    chk("req38_cnt", int'(cnt_ov) + int'(cnt_no) + int'(cnt_c2), 0);
    model_reset();
    #1 rst = 0;
    send(1'b1, "s38u");
    load(8'h0B, 4'd4, "ld38");
    send(1'b1, "s38a"); send(1'b1, "s38a");
    for (int i = 3; i >= 0; i--) send(s1011[i], "s38b");
    chk("req38_hit", int'(cnt_ov), 1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cfg_load    = ($urandom % 40) == 0;
      cfg_len     = (($urandom % 12) < 10) ? 4'($urandom_range(1, 4)) : 4'($urandom % 16);
      cfg_pattern = 8'($urandom);
      in_valid    = ($urandom % 4) != 0;
      in_bit      = 1'($urandom);
      cnt_clr     = ($urandom % 50) == 0;
      step("rnd");
    end
    cfg_load = 0; in_valid = 0; cnt_clr = 0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
